// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and the baud-divider
// calculation used for the default bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned BAUD      = 115_200;
  localparam int unsigned DATA_BITS = 8;

  // Integer sys_clk cycles per UART bit; 50 MHz / 115200 gives 434.
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored, so the level can never leave 0..DEPTH.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state is assigned with <= so all flops update from pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; the pointers and level alone define valid contents.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a serializer that
// sends frames back-to-back while bytes remain queued.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter  int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD),
  parameter  int unsigned DEPTH    = 16,
  localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          tx_send,
  input  logic [7:0]    tx_data,
  input  logic          clr_overflow,
  output logic          tx_full,
  output logic          tx_empty,
  output logic [LW-1:0] tx_level,
  output logic          tx_busy,
  output logic          tx_overflow,
  output logic          uart_txd
);

  localparam int unsigned   CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          baud_end;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (tx_send),
    .pop     (fifo_pop),
    .din     (tx_data),
    .dout    (fifo_dout),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  assign baud_end    = (baud_cnt_q == BAUD_LAST);
  assign tx_busy     = (state_q != ST_IDLE) || !tx_empty;
  assign tx_overflow = ovf_q;
  assign uart_txd    = txd_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_end ? '0 : baud_cnt_q + CW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    fifo_pop   = 1'b0;

    // uart_txd is registered, so it is loaded with the level of the state being entered.
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
        if (!tx_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = ST_START;
          txd_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (!tx_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = ST_START;
            txd_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // A dropped byte sets the flag even when a clear arrives in the same cycle.
    ovf_d = ovf_q;
    if (tx_send && tx_full) ovf_d = 1'b1;
    else if (clr_overflow)  ovf_d = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf (BAUD_DIV=4, DEPTH=4): a serial
// receiver pops expected bytes from a scoreboard as frames complete.
module tb_uart_tx_buf;

  localparam int BAUD_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int LW       = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          tx_send;
  logic [7:0]    tx_data;
  logic          clr_overflow;
  logic          tx_full, tx_empty, tx_busy, tx_overflow, uart_txd;
  logic [LW-1:0] tx_level;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] sb[$];
  int         start_q[$];

  uart_tx_buf #(
    .BAUD_DIV (BAUD_DIV),
    .DEPTH    (DEPTH)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .tx_send      (tx_send),
    .tx_data      (tx_data),
    .clr_overflow (clr_overflow),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_level     (tx_level),
    .tx_busy      (tx_busy),
    .tx_overflow  (tx_overflow),
    .uart_txd     (uart_txd)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc = cyc + 1;

  // Serial receiver: frame timing relative to the first start-bit cycle (cnt 0).
  bit         rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;

  always @(negedge sys_clk) begin
    if (sys_rst === 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_txd === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 2) begin
        checks++;
        if (uart_txd !== 1'b0) begin errors++; $display("FAIL rx_start_bit: got %b want 0 at cyc %0d", uart_txd, cyc); end
      end
      if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % BAUD_DIV) == 0)
        rx_byte[(rx_cnt - 6) / BAUD_DIV] = uart_txd;
      if (rx_cnt == 38) begin
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL rx_stop_bit: got %b want 1 at cyc %0d", uart_txd, cyc); end
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rx_unexpected_frame: got %02h want no frame", rx_byte);
        end else begin
          rx_exp = sb.pop_front();
          if (rx_byte !== rx_exp) begin errors++; $display("FAIL rx_byte: got %02h want %02h", rx_byte, rx_exp); end
        end
        rx_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    tx_send = 1'b1;
    tx_data = b;
    if (accepted) sb.push_back(b);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((tx_busy !== 1'b0 || rx_active) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, tx_busy, budget); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL %s_sb_left: got %0d bytes pending want 0", name, sb.size()); end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; tx_send = 1'b0; tx_data = 8'h00; clr_overflow = 1'b0;
    tick(); tick();
    checks += 6;
    if (uart_txd !== 1'b1)    begin errors++; $display("FAIL rst_txd: got %b want 1", uart_txd); end
    if (tx_level !== 3'd0)    begin errors++; $display("FAIL rst_level: got %0d want 0", tx_level); end
    if (tx_empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %b want 1", tx_empty); end
    if (tx_full !== 1'b0)     begin errors++; $display("FAIL rst_full: got %b want 0", tx_full); end
    if (tx_busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    if (tx_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", tx_overflow); end
    sys_rst = 1'b0;
  endtask

  task automatic test_single_byte();
    logic [7:0] pat = 8'hA5;
    logic       exp_txd, exp_busy;
    tick();
    push(8'hA5, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 1) tx_send = 1'b0;
      if (k >= 2 && k <= 5)       exp_txd = 1'b0;
      else if (k >= 6 && k <= 37) exp_txd = pat[(k - 6) / BAUD_DIV];
      else                        exp_txd = 1'b1;
      exp_busy = (k <= 41);
      checks += 2;
      if (uart_txd !== exp_txd) begin errors++; $display("FAIL single_txd: cycle %0d got %b want %b", k, uart_txd, exp_txd); end
      if (tx_busy !== exp_busy) begin errors++; $display("FAIL single_busy: cycle %0d got %b want %b", k, tx_busy, exp_busy); end
      if (k == 1) begin
        checks++;
        if (tx_level !== 3'd1) begin errors++; $display("FAIL single_level1: got %0d want 1", tx_level); end
      end
      if (k == 2) begin
        checks++;
        if (tx_level !== 3'd0) begin errors++; $display("FAIL single_level2: got %0d want 0", tx_level); end
      end
    end
    wait_idle("single", 20);
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    int n    = 0;
    tick();
    start_q.delete();
    push(8'h01, 1'b1); tick();
    push(8'h02, 1'b1); tick();
    push(8'h03, 1'b1); tick();
    tx_send = 1'b0;
    while ((tx_busy !== 1'b0 || rx_active) && n < 200) begin
      if (int'(tx_level) > peak) peak = int'(tx_level);
      tick();
      n++;
    end
    checks++;
    if (peak != 2) begin errors++; $display("FAIL b2b_peak_level: got %0d want 2", peak); end
    checks++;
    if (start_q.size() != 3) begin
      errors++; $display("FAIL b2b_frames: got %0d want 3", start_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (start_q[i] - start_q[i-1] != 10 * BAUD_DIV)
          begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", start_q[i] - start_q[i-1], 10 * BAUD_DIV); end
      end
    end
    wait_idle("b2b", 50);
  endtask

  task automatic test_overflow();
    tick();
    push(8'h0F, 1'b1); tick();
    tx_send = 1'b0; tick(); tick();
    for (int i = 0; i < 4; i++) begin
      push(8'h10 + 8'(i), 1'b1);
      tick();
    end
    checks++;
    if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", tx_full); end
    push(8'h14, 1'b0);
    tick();
    tx_send = 1'b0;
    checks += 2;
    if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", tx_overflow); end
    if (tx_level !== 3'd4)    begin errors++; $display("FAIL ovf_level: got %0d want 4", tx_level); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++;
    if (tx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", tx_overflow); end
    wait_idle("ovf", 300);
  endtask

  task automatic test_full_pop_collision();
    tick();
    for (int i = 0; i < 5; i++) begin
      push(8'h21 + 8'(i), 1'b1);
      tick();
    end
    tx_send = 1'b0;
    checks += 2;
    if (tx_full !== 1'b1)  begin errors++; $display("FAIL coll_full: got %b want 1", tx_full); end
    if (tx_level !== 3'd4) begin errors++; $display("FAIL coll_level4: got %0d want 4", tx_level); end
    for (int k = 6; k <= 41; k++) tick();
    checks++;
    if (tx_full !== 1'b1) begin errors++; $display("FAIL coll_full41: got %b want 1", tx_full); end
    push(8'h55, 1'b0);
    clr_overflow = 1'b1;
    tick();
    tx_send = 1'b0;
    clr_overflow = 1'b0;
    checks += 3;
    if (tx_level !== 3'(DEPTH - 1)) begin errors++; $display("FAIL coll_level: got %0d want %0d", tx_level, DEPTH - 1); end
    if (tx_overflow !== 1'b1)       begin errors++; $display("FAIL coll_ovf_set_wins: got %b want 1", tx_overflow); end
    if (tx_full !== 1'b0)           begin errors++; $display("FAIL coll_not_full: got %b want 0", tx_full); end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++;
    if (tx_overflow !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b want 0", tx_overflow); end
    wait_idle("coll", 400);
  endtask

  task automatic test_reset_mid_frame();
    tick();
    push(8'hFF, 1'b1); tick();
    push(8'h11, 1'b1); tick();
    push(8'h22, 1'b1); tick();
    tx_send = 1'b0;
    for (int k = 4; k <= 19; k++) tick();
    checks += 2;
    if (tx_level !== 3'd2)  begin errors++; $display("FAIL midrst_queued: got %0d want 2", tx_level); end
    if (uart_txd !== 1'b1)  begin errors++; $display("FAIL midrst_bit3: got %b want 1", uart_txd); end
    sys_rst = 1'b1;
    sb.delete();
    tick();
    checks += 5;
    if (uart_txd !== 1'b1)    begin errors++; $display("FAIL midrst_txd: got %b want 1", uart_txd); end
    if (tx_level !== 3'd0)    begin errors++; $display("FAIL midrst_level: got %0d want 0", tx_level); end
    if (tx_busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
    if (tx_empty !== 1'b1)    begin errors++; $display("FAIL midrst_empty: got %b want 1", tx_empty); end
    if (tx_overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", tx_overflow); end
    tick();
    sys_rst = 1'b0;
    tick();
    push(8'h00, 1'b1);
    tick();
    tx_send = 1'b0;
    checks++;
    if (uart_txd !== 1'b1) begin errors++; $display("FAIL midrst_c1_txd: got %b want 1", uart_txd); end
    tick();
    checks++;
    if (uart_txd !== 1'b0) begin errors++; $display("FAIL midrst_c2_start: got %b want 0", uart_txd); end
    wait_idle("midrst", 100);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_full_pop_collision();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, meaning sys_clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; a power of 2, >= 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 sys_clk  in  1  the single clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  synchronous active-high reset.
REQ-006 tx_send  in  1  one-cycle write strobe from the command engine.
REQ-007 tx_data  in  8  byte to transmit, sampled when tx_send=1.
REQ-008 clr_overflow  in  1  clears tx_overflow.
REQ-009 tx_full  out  1  FIFO holds DEPTH bytes.
REQ-010 tx_empty  out  1  FIFO holds 0 bytes.
REQ-011 tx_level  out  log2(DEPTH)+1  bytes currently in the FIFO.
REQ-012 tx_busy  out  1  FIFO non-empty or serializer not IDLE.
REQ-013 tx_overflow  out  1  sticky flag: a byte was dropped.
REQ-014 uart_txd  out  1  8N1 serial output, idle high, registered.

Function
REQ-015 SHALL accept a push when tx_send=1 and the registered tx_full=0; the byte is appended and tx_level increments on the next edge.
REQ-016 SHALL drop the byte when tx_send=1 and tx_full=1, even if a pop happens in the same cycle, and set tx_overflow=1 on the next edge.
REQ-017 On a push and a pop in the same cycle with 0<tx_level<DEPTH, tx_level SHALL stay unchanged and byte order SHALL be preserved.
REQ-018 Pointers SHALL wrap modulo DEPTH; tx_level SHALL saturate at neither end, because the push/pop rules prevent over- and underflow.
REQ-019 tx_overflow SHALL clear one cycle after clr_overflow=1; if clr_overflow=1 and an overflow occur in the same cycle, set SHALL win.
REQ-020 The serializer SHALL have states IDLE, START, DATA, STOP and a bit counter 0..7.
REQ-021 In IDLE with tx_empty=0, it SHALL pop one byte into a shift register and enter START on the next edge.
REQ-022 START SHALL drive uart_txd=0 for BAUD_DIV cycles, then go to DATA.
REQ-023 DATA SHALL send 8 bits LSB first, each for BAUD_DIV cycles, then go to STOP.
REQ-024 STOP SHALL drive uart_txd=1 for BAUD_DIV cycles. At the end, if tx_empty=0, it SHALL pop and go directly to START, so frames run back-to-back at 10*BAUD_DIV cycles each. Otherwise it SHALL go to IDLE.
REQ-025 Latency with the FIFO empty and the serializer IDLE:
  - tx_send at cycle 0 -> tx_level=1 at cycle 1
  - pop at cycle 1 -> uart_txd=0 from cycle 2
  - tx_level=0 at cycle 2
REQ-026 IDLE SHALL drive uart_txd=1; the baud counter SHALL count 0..BAUD_DIV-1 and restart at every state change.
REQ-027 tx_busy SHALL be 0 only when IDLE and tx_empty=1.

Reset
REQ-028 On sys_rst=1 at an edge, all of the following SHALL hold, including mid-frame:
  - uart_txd=1, state=IDLE, tx_level=0, tx_empty=1, tx_full=0, tx_busy=0, tx_overflow=0
  - pointers and counters = 0
  - the frame in progress is aborted with no stop bit
REQ-029 Inputs SHALL be ignored while sys_rst=1; FIFO storage contents need not reset.

Structure
REQ-030 Shared package uart_pkg SHALL hold the serializer state enum and the BAUD_DIV calculation constant/function (CLK_FREQ/BAUD).
REQ-031 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level); uart_tx_buf contains the serializer and the overflow logic.

Verification (BAUD_DIV=4, DEPTH=4)
REQ-032 Single byte: push 0xA5 at cycle 0 -> uart_txd=0 for cycles 2-5, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for cycles 38-41; tx_busy=0 from cycle 42.
REQ-033 Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles -> three frames with no idle gap between stop and start, 40 cycles apart, in order; tx_level peaks at 2.
REQ-034 Overflow: while the first frame is sending, push 0x10..0x14 (5 bytes) -> tx_full=1 after the 4th push, 0x14 dropped, tx_overflow=1; clr_overflow -> tx_overflow=0; bytes 0x10-0x13 transmitted.
REQ-035 Full + pop collision: with tx_full=1, push 0x55 in the same cycle the serializer pops -> 0x55 dropped, tx_overflow=1, tx_level=DEPTH-1 next cycle.
REQ-036 Reset mid-frame: assert sys_rst during DATA bit 3 of 0xFF with 2 bytes queued -> next edge uart_txd=1, tx_level=0, tx_busy=0; after release, push 0x00 -> a clean frame starts 2 cycles later.
